// File: rtl/mux_select_sequencer_if.sv
// Handshake and mux-drive bundle between an upstream word source and mux_select_sequencer.
interface mux_select_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  mux_sel;
  logic              sel_valid;
  logic              sel_last;
  logic              done;
  logic              busy;

  // master is the upstream word source; slave is the sequencer
  modport master (
    output in_valid, in_data,
    input  in_ready, mux_data, mux_sel, sel_valid, sel_last, done, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mux_data, mux_sel, sel_valid, sel_last, done, busy
  );
endinterface

// File: rtl/mux_select_sequencer.sv
// Drives an 8:1 mux: latches a word, then walks the select through every code, HOLD_CYCLES each.
// Define SEQ_DESCEND_EN to serialise MSB first (select 7 down to 0) instead of LSB first.
module mux_select_sequencer #(
  parameter int DATA_W      = 8,
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  mux_select_sequencer_if.slave bus
);

  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

`ifdef SEQ_DESCEND_EN
  localparam logic [SEL_W-1:0] START_CODE = SEL_W'(DATA_W - 1);
  localparam logic [SEL_W-1:0] FINAL_CODE = '0;
`else
  localparam logic [SEL_W-1:0] START_CODE = '0;
  localparam logic [SEL_W-1:0] FINAL_CODE = SEL_W'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   mux_data, data_nx;
  logic [SEL_W-1:0]    mux_sel, sel_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mux_data <= '0;
      mux_sel  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      mux_data <= data_nx;
      mux_sel  <= sel_nx;
      hold_cnt <= hold_nx;
    end
  end

  // in_ready is IDLE qualified by rst, so a handshake under reset never looks accepted
  always_comb begin
    state_nx = state;
    data_nx  = mux_data;
    sel_nx   = mux_sel;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          data_nx  = bus.in_data;
          sel_nx   = START_CODE;
          hold_nx  = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_nx = '0;
          if (mux_sel == FINAL_CODE) begin
            state_nx = DONE;
          end else begin
`ifdef SEQ_DESCEND_EN
            sel_nx = mux_sel - SEL_W'(1);
`else
            sel_nx = mux_sel + SEL_W'(1);
`endif
          end
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.busy      = (state == RUN);
  assign bus.sel_valid = (state == RUN);
  assign bus.sel_last  = (state == RUN) && (mux_sel == FINAL_CODE);
  assign bus.done      = (state == DONE);
  assign bus.mux_data  = mux_data;
  assign bus.mux_sel   = mux_sel;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: a HOLD_CYCLES=1 and a HOLD_CYCLES=2 instance checked against a word-level model.
// Build with +define+SEQ_DESCEND_EN to check the MSB-first ordering.
module tb_mux_select_sequencer;

`ifdef SEQ_DESCEND_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_select_sequencer_if #(.DATA_W(8), .SEL_W(3)) bus_h1 ();
  mux_select_sequencer_if #(.DATA_W(8), .SEL_W(3)) bus_h2 ();

  mux_select_sequencer #(.DATA_W(8), .SEL_W(3), .HOLD_CYCLES(1)) dut_h1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_h1.slave)
  );

  mux_select_sequencer #(.DATA_W(8), .SEL_W(3), .HOLD_CYCLES(2)) dut_h2 (
    .clk (clk),
    .rst (rst),
    .bus (bus_h2.slave)
  );

  // Layout: {in_ready, busy, sel_valid, sel_last, done, mux_sel[2:0], mux_out, mux_data[7:0]}
  function automatic logic [16:0] snap(input int d);
    logic [7:0] md;
    logic [2:0] ms;
    logic [4:0] ctl;
    if (d == 0) begin
      md  = bus_h1.mux_data;
      ms  = bus_h1.mux_sel;
      ctl = {bus_h1.in_ready, bus_h1.busy, bus_h1.sel_valid, bus_h1.sel_last, bus_h1.done};
    end else begin
      md  = bus_h2.mux_data;
      ms  = bus_h2.mux_sel;
      ctl = {bus_h2.in_ready, bus_h2.busy, bus_h2.sel_valid, bus_h2.sel_last, bus_h2.done};
    end
    return {ctl, ms, md[ms], md};
  endfunction

  // Control flags and data only, for cycles where the select value is don't-care
  function automatic logic [16:0] snap_ctl(input int d);
    logic [16:0] s;
    s = snap(d);
    return {4'b0, s[16:12], s[7:0]};
  endfunction

  function automatic logic [2:0] code_at(input int i, input int hold);
    int step;
    step = i / hold;
    return DESC ? 3'(7 - step) : 3'(step);
  endfunction

  task automatic check_output(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] w);
    if (d == 0) begin
      bus_h1.in_valid = v;
      bus_h1.in_data  = w;
    end else begin
      bus_h2.in_valid = v;
      bus_h2.in_data  = w;
    end
  endtask

  // Present a word while idle and clock it in; returns on the negedge after the accepting edge
  task automatic apply_stimulus(input int d, input logic [7:0] w);
    logic [16:0] s;
    drive(d, 1'b1, w);
    #1;
    s = snap(d);
    check_output($sformatf("accept_ready[d%0d]", d), {16'b0, s[16]}, 17'd1);
    tick();
  endtask

  // Walk one accepted word through all select steps, the done cycle and the following idle cycle
  task automatic run_word(input int d, input logic [7:0] w);
    int hold;
    logic [2:0] code;
    logic last;
    hold = (d == 0) ? 1 : 2;
    for (int i = 0; i < 8 * hold; i++) begin
      code = code_at(i, hold);
      last = (i / hold) == 7;
      check_output($sformatf("run[d%0d w%02h i%0d]", d, w, i), snap(d),
                   {1'b0, 1'b1, 1'b1, last, 1'b0, code, w[code], w});
      tick();
    end
    check_output($sformatf("done[d%0d w%02h]", d, w), snap_ctl(d), {4'b0, 5'b00001, w});
    tick();
    check_output($sformatf("idle[d%0d w%02h]", d, w), snap_ctl(d), {4'b0, 5'b10000, w});
  endtask

  initial begin
    logic [7:0] w;
    int d;

    // Reset held for three edges with a word offered on both instances
    rst = 1'b1;
    drive(0, 1'b1, 8'h3C);
    drive(1, 1'b1, 8'hC3);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("reset_h1[%0d]", k), snap(0), 17'b0);
      check_output($sformatf("reset_h2[%0d]", k), snap(1), 17'b0);
    end
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    #1;
    check_output("release_h1", snap(0), {5'b10000, 3'd0, 1'b0, 8'h00});
    check_output("release_h2", snap(1), {5'b10000, 3'd0, 1'b0, 8'h00});
    tick();
    check_output("release_idle_h2", snap(1), {5'b10000, 3'd0, 1'b0, 8'h00});

    // Directed word on the two-cycle-hold instance
    $display("[TB] basic word, hold 2");
    apply_stimulus(1, 8'b01001001);
    drive(1, 1'b0, 8'h00);
    run_word(1, 8'b01001001);

    // Backpressure: 8'hA5 offered throughout the run is taken right after done
    $display("[TB] backpressure");
    apply_stimulus(1, 8'h5A);
    drive(1, 1'b1, 8'hA5);
    run_word(1, 8'h5A);
    tick();
    drive(1, 1'b0, 8'h00);
    run_word(1, 8'hA5);

    // Single-cycle hold instance
    $display("[TB] hold 1");
    apply_stimulus(0, 8'hFF);
    drive(0, 1'b0, 8'h00);
    run_word(0, 8'hFF);
    apply_stimulus(0, 8'h80);
    drive(0, 1'b0, 8'h00);
    run_word(0, 8'h80);

    // Random words on random instances
    $display("[TB] random words");
    for (int n = 0; n < 8; n++) begin
      d = int'($urandom_range(0, 1));
      w = 8'($urandom);
      apply_stimulus(d, w);
      drive(d, 1'b0, 8'h00);
      run_word(d, w);
    end

    // Reset in the middle of a word, at the fifth select step
    $display("[TB] mid-word reset");
    w = 8'($urandom);
    apply_stimulus(1, w);
    drive(1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    check_output("midreset_pre", snap(1),
                 {5'b01100, code_at(8, 2), w[code_at(8, 2)], w});
    rst = 1'b1;
    tick();
    check_output("midreset_in", snap(1), 17'b0);
    rst = 1'b0;
    #1;
    check_output("midreset_release", snap(1), {5'b10000, 3'd0, 1'b0, 8'h00});
    tick();
    check_output("midreset_nodone", snap(1), {5'b10000, 3'd0, 1'b0, 8'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
